// File: rtl/dadda_mult_8x8.sv
// Unsigned 8x8 multiplier: Dadda tree (8->6->4->3->2), ripple CPA, registered product.
module dadda_mult_8x8 (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] y
);

   localparam int NSTG = 4;
   localparam int TGT [NSTG] = '{6, 4, 3, 2};

   logic [15:0] row0;
   logic [15:0] row1;
   logic [15:0] prod;

   // Column heights are data-independent, so every loop below unrolls
   // into a fixed network of full/half adders.
   always_comb begin : tree
      logic [7:0] cur [16];
      logic [7:0] nxt [16];
      int         h   [16];
      int         nh  [16];
      int         ex;
      int         p;
      logic       x0, x1, x2;

      row0 = '0;
      row1 = '0;
      x0   = 1'b0;
      x1   = 1'b0;
      x2   = 1'b0;
      ex   = 0;
      p    = 0;
      for (int c = 0; c < 16; c++) begin
         cur[c] = '0;
         nxt[c] = '0;
         h[c]   = 0;
         nh[c]  = 0;
      end

      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            cur[i+j][h[i+j]] = A[j] & B[i];
            h[i+j] = h[i+j] + 1;
         end
      end

      for (int s = 0; s < NSTG; s++) begin
         for (int c = 0; c < 16; c++) begin
            nxt[c] = '0;
            nh[c]  = 0;
         end
         for (int c = 0; c < 16; c++) begin
            // nh[c] already holds carries arriving from column c-1
            ex = h[c] + nh[c] - TGT[s];
            p  = 0;
            while (ex > 0) begin
               x0 = cur[c][p];
               x1 = cur[c][p+1];
               if (ex >= 2) begin
                  x2 = cur[c][p+2];
                  nxt[c][nh[c]] = x0 ^ x1 ^ x2;
                  nh[c] = nh[c] + 1;
                  if (c < 15) begin
                     nxt[c+1][nh[c+1]] = (x0 & x1) | (x2 & (x0 ^ x1));
                     nh[c+1] = nh[c+1] + 1;
                  end
                  p  = p + 3;
                  ex = ex - 2;
               end else begin
                  nxt[c][nh[c]] = x0 ^ x1;
                  nh[c] = nh[c] + 1;
                  if (c < 15) begin
                     nxt[c+1][nh[c+1]] = x0 & x1;
                     nh[c+1] = nh[c+1] + 1;
                  end
                  p  = p + 2;
                  ex = ex - 1;
               end
            end
            while (p < h[c]) begin
               nxt[c][nh[c]] = cur[c][p];
               nh[c] = nh[c] + 1;
               p = p + 1;
            end
         end
         for (int c = 0; c < 16; c++) begin
            cur[c] = nxt[c];
            h[c]   = nh[c];
         end
      end

      for (int c = 0; c < 16; c++) begin
         row0[c] = cur[c][0];
         row1[c] = cur[c][1];
      end
   end

   // Carry out of bit 15 is always zero for 8x8 operands.
   always_comb begin : cpa
      logic cy;
      cy   = 1'b0;
      prod = '0;
      for (int i = 0; i < 16; i++) begin
         prod[i] = row0[i] ^ row1[i] ^ cy;
         cy = (row0[i] & row1[i]) | (cy & (row0[i] ^ row1[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) y <= '0;
      else     y <= prod;
   end

endmodule

// File: tb/tb_dadda_mult_8x8.sv
// Self-checking bench for dadda_mult_8x8 against a behavioural A*B model.
module tb_dadda_mult_8x8;

   logic        clk;
   logic        rst;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] y;

   int errors = 0;
   int checks = 0;

   dadda_mult_8x8 dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
      int unsigned r;
      r = int'(a) * int'(b);
      return r[15:0];
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      A   = 8'hFF;
      B   = 8'hFF;
      @(negedge clk);
      checks++;
      if (y !== 16'h0000) begin
         errors++;
         $display("FAIL reset_clear: y=%0d expected=0", y);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (y !== 16'd65025) begin
         errors++;
         $display("FAIL reset_release: y=%0d expected=65025", y);
      end
   endtask

   task automatic test_identity();
      logic [7:0]  av [3];
      logic [7:0]  bv [3];
      logic [15:0] ev [3];
      av = '{8'd0, 8'd1, 8'd200};
      bv = '{8'd173, 8'd173, 8'd1};
      ev = '{16'd0, 16'd173, 16'd200};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         A = av[k];
         B = bv[k];
         @(negedge clk);
         checks++;
         if (y !== ev[k]) begin
            errors++;
            $display("FAIL identity: A=%0d B=%0d y=%0d expected=%0d",
                     av[k], bv[k], y, ev[k]);
         end
      end
   endtask

   task automatic test_max();
      logic [7:0]  av [2];
      logic [15:0] ev [2];
      av = '{8'hFF, 8'h80};
      ev = '{16'hFE01, 16'h4000};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         A = av[k];
         B = av[k];
         @(negedge clk);
         checks++;
         if (y !== ev[k]) begin
            errors++;
            $display("FAIL max_carry: A=%0d y=%h expected=%h", av[k], y, ev[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  av [3];
      logic [7:0]  bv [3];
      logic [15:0] ev [3];
      av = '{8'd3, 8'd12, 8'd255};
      bv = '{8'd5, 8'd11, 8'd2};
      ev = '{16'd15, 16'd132, 16'd510};
      @(negedge clk);
      A = av[0];
      B = bv[0];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (y !== ev[k]) begin
            errors++;
            $display("FAIL back_to_back[%0d]: y=%0d expected=%0d", k, y, ev[k]);
         end
         if (k < 2) begin
            A = av[k+1];
            B = bv[k+1];
         end
      end
   endtask

   task automatic test_midstream_reset();
      @(negedge clk);
      A = 8'd77;
      B = 8'd91;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (y !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset: y=%0d expected=0", y);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (y !== model(8'd77, 8'd91)) begin
         errors++;
         $display("FAIL mid_release: y=%0d expected=%0d", y, model(8'd77, 8'd91));
      end
   endtask

   task automatic test_random();
      logic [7:0]  pa;
      logic [7:0]  pb;
      logic [15:0] exp_y;
      @(negedge clk);
      pa = 8'($urandom);
      pb = 8'($urandom);
      A  = pa;
      B  = pb;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         exp_y = model(pa, pb);
         checks++;
         if (y !== exp_y) begin
            errors++;
            $display("FAIL random *ERROR*: A=%0d B=%0d y=%0d expected=%0d",
                     pa, pb, y, exp_y);
         end
         pa = 8'($urandom);
         pb = 8'($urandom);
         A  = pa;
         B  = pb;
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0]  pa;
      logic [7:0]  pb;
      logic [15:0] exp_y;
      int          bad;
      bad = 0;
      @(negedge clk);
      pa = 8'd0;
      pb = 8'd0;
      A  = pa;
      B  = pb;
      for (int k = 0; k < 65536; k++) begin
         @(negedge clk);
         exp_y = model(pa, pb);
         checks++;
         if (y !== exp_y) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL exhaustive: A=%0d B=%0d y=%0d expected=%0d",
                        pa, pb, y, exp_y);
         end
         pa = 8'((k + 1) % 256);
         pb = 8'((k + 1) / 256);
         A  = pa;
         B  = pb;
      end
   endtask

   initial begin
      rst = 1'b1;
      A   = 8'h00;
      B   = 8'h00;
      repeat (2) @(negedge clk);
      test_reset();
      test_identity();
      test_max();
      test_back_to_back();
      test_midstream_reset();
      test_random();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
